// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM state, resume encoding and register index width.
// Optional performance counters are enabled in the top module with the HAZARD_PERF_EN macro.
package hazard_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    REDIRECT = 2'd2,
    MEM_WAIT = 2'd3
  } state_t;

  // The resume register remembers which state a memory freeze interrupted
  typedef enum logic [1:0] {
    RES_RUN      = 2'd0,
    RES_LU_STALL = 2'd1,
    RES_REDIRECT = 2'd2
  } resume_t;

  function automatic state_t resume_to_state(input resume_t r);
    state_t s;
    case (r)
      RES_LU_STALL: s = LU_STALL;
      RES_REDIRECT: s = REDIRECT;
      default:      s = RUN;
    endcase
    return s;
  endfunction

  function automatic resume_t state_to_resume(input state_t s);
    resume_t r;
    case (s)
      LU_STALL: r = RES_LU_STALL;
      REDIRECT: r = RES_REDIRECT;
      default:  r = RES_RUN;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator: a load in EX whose destination feeds an ID source operand.
// Register x0 never creates a dependency.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  output logic             load_use
);

  logic rd_nonzero;
  logic rs_match;

  assign rd_nonzero = (ex_rd != '0);
  assign rs_match   = (ex_rd == id_rs1) || (ex_rd == id_rs2);
  assign load_use   = ex_mem_read && rd_nonzero && rs_match;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and data-memory freezes.
// Define HAZARD_PERF_EN to add the saturating stall_cycles / flush_events counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             branch_taken,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
`endif
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  state_t  state;
  state_t  state_next;
  state_t  eff_state;
  resume_t resume;
  resume_t resume_next;
  logic    load_use;

  hazard_detect u_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .load_use    (load_use)
  );

  // A released freeze behaves as the interrupted state within the same cycle
  always_comb begin
    eff_state = state;
    if (state == MEM_WAIT && !mem_busy) begin
      eff_state = resume_to_state(resume);
    end
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    state_next  = eff_state;
    resume_next = resume;

    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
      state_next  = RUN;
      resume_next = RES_RUN;
    end else if (mem_busy) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_flush = 1'b1;
      state_next  = MEM_WAIT;
      if (state != MEM_WAIT) begin
        resume_next = state_to_resume(state);
      end
    end else begin
      case (eff_state)
        RUN: begin
          // A taken branch squashes the dependent younger instruction, so no stall
          if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_next = REDIRECT;
          end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            state_next = LU_STALL;
          end else begin
            state_next = RUN;
          end
        end
        LU_STALL: begin
          state_next = RUN;
        end
        REDIRECT: begin
          ifid_flush = 1'b1;
          state_next = RUN;
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      resume <= RES_RUN;
    end else begin
      state  <= state_next;
      resume <= resume_next;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!pc_write) begin
        stall_cycles <= sat_inc(stall_cycles);
      end
      if (state_next == REDIRECT) begin
        flush_events <= sat_inc(flush_events);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl; counter checks are included when HAZARD_PERF_EN is defined.
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic       mb;
    logic       br;
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } stim_t;

  // Output vector order: pc, ifid_w, idex_w, exmem_w, ifid_f, idex_f, memwb_f
  localparam logic [6:0] DEF  = 7'b1111_000;
  localparam logic [6:0] RST  = 7'b0000_111;
  localparam logic [6:0] MEMW = 7'b0000_001;
  localparam logic [6:0] BR   = 7'b1111_110;
  localparam logic [6:0] LU   = 7'b0011_010;
  localparam logic [6:0] RED  = 7'b1111_100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       branch_taken = 1'b0;
  logic       ex_mem_read = 1'b0;
  logic [4:0] ex_rd = '0;
  logic [4:0] id_rs1 = '0;
  logic [4:0] id_rs2 = '0;
  logic       mem_busy = 1'b0;
  logic       pc_write, ifid_write, idex_write, exmem_write;
  logic       ifid_flush, idex_flush, memwb_flush;
  logic [6:0] outs;
`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cycles;
  logic [15:0] flush_events;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .branch_taken (branch_taken),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .mem_busy     (mem_busy),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .idex_write   (idex_write),
    .exmem_write  (exmem_write),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .memwb_flush  (memwb_flush)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
`endif
  );

  assign outs = {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush, memwb_flush};

  function automatic stim_t mk(input logic rst, input logic mb, input logic br, input logic mr,
                               input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    stim_t s;
    s = {rst, mb, br, mr, rd, rs1, rs2};
    return s;
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1ns later, well before the rising edge
  task automatic apply(input stim_t s);
    @(negedge clk);
    reset        = s.rst;
    mem_busy     = s.mb;
    branch_taken = s.br;
    ex_mem_read  = s.mr;
    ex_rd        = s.rd;
    id_rs1       = s.rs1;
    id_rs2       = s.rs2;
    #1;
  endtask

  task automatic test_reset();
    stim_t s [3];
    logic [6:0] e [3];
    s = '{mk(1,0,0,0,0,0,0), mk(1,1,1,1,5,5,5), mk(0,0,0,0,0,0,0)};
    e = '{RST, RST, DEF};
    for (int i = 0; i < 3; i++) begin
      apply(s[i]);
      checks++;
      if (outs !== e[i]) begin
        errors++;
        $display("FAIL reset[%0d] got=%b expected=%b", i, outs, e[i]);
      end
    end
`ifdef HAZARD_PERF_EN
    checks++;
    if (stall_cycles !== 16'd0 || flush_events !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters got=%0d/%0d expected=0/0", stall_cycles, flush_events);
    end
`endif
  endtask

  task automatic test_load_use();
    stim_t s [9];
    logic [6:0] e [9];
    s = '{mk(1,0,0,0,0,0,0), mk(0,0,0,1,5,1,5), mk(0,0,0,1,5,1,5), mk(0,0,0,1,5,1,5),
          mk(0,1,0,1,5,1,5), mk(0,0,0,1,5,1,5), mk(0,0,0,1,5,1,5), mk(0,0,0,0,0,0,0),
          mk(0,0,0,0,0,0,0)};
    e = '{RST, LU, DEF, LU, MEMW, DEF, LU, DEF, DEF};
    for (int i = 0; i < 9; i++) begin
      apply(s[i]);
      checks++;
      if (outs !== e[i]) begin
        errors++;
        $display("FAIL load_use[%0d] got=%b expected=%b", i, outs, e[i]);
      end
    end
  endtask

  task automatic test_branch();
    stim_t s [8];
    logic [6:0] e [8];
    s = '{mk(1,0,0,0,0,0,0), mk(0,0,1,0,0,0,0), mk(0,0,1,0,0,0,0), mk(0,0,0,0,0,0,0),
          mk(0,1,1,0,0,0,0), mk(0,0,1,0,0,0,0), mk(0,0,0,0,0,0,0), mk(0,0,0,0,0,0,0)};
    e = '{RST, BR, RED, DEF, MEMW, BR, RED, DEF};
    for (int i = 0; i < 8; i++) begin
      apply(s[i]);
      checks++;
      if (outs !== e[i]) begin
        errors++;
        $display("FAIL branch[%0d] got=%b expected=%b", i, outs, e[i]);
      end
    end
`ifdef HAZARD_PERF_EN
    checks++;
    if (flush_events !== 16'd2 || stall_cycles !== 16'd1) begin
      errors++;
      $display("FAIL branch_counters got=%0d/%0d expected=1/2", stall_cycles, flush_events);
    end
`endif
  endtask

  task automatic test_mem_wait();
    stim_t s [7];
    logic [6:0] e [7];
    s = '{mk(1,0,0,0,0,0,0), mk(0,0,1,0,0,0,0), mk(0,1,0,0,0,0,0), mk(0,1,1,0,0,0,0),
          mk(0,1,0,1,2,2,0), mk(0,0,0,0,0,0,0), mk(0,0,0,0,0,0,0)};
    e = '{RST, BR, MEMW, MEMW, MEMW, RED, DEF};
    for (int i = 0; i < 7; i++) begin
      apply(s[i]);
      checks++;
      if (outs !== e[i]) begin
        errors++;
        $display("FAIL mem_wait[%0d] got=%b expected=%b", i, outs, e[i]);
      end
    end
`ifdef HAZARD_PERF_EN
    checks++;
    if (stall_cycles !== 16'd3 || flush_events !== 16'd1) begin
      errors++;
      $display("FAIL mem_wait_counters got=%0d/%0d expected=3/1", stall_cycles, flush_events);
    end
`endif
  endtask

  task automatic test_branch_and_load_use();
    stim_t s [4];
    logic [6:0] e [4];
    s = '{mk(1,0,0,0,0,0,0), mk(0,0,1,1,4,4,0), mk(0,0,0,1,4,4,0), mk(0,0,0,0,0,0,0)};
    e = '{RST, BR, RED, DEF};
    for (int i = 0; i < 4; i++) begin
      apply(s[i]);
      checks++;
      if (outs !== e[i]) begin
        errors++;
        $display("FAIL branch_lu[%0d] got=%b expected=%b", i, outs, e[i]);
      end
    end
  endtask

  task automatic test_rd_zero();
    stim_t s [7];
    logic [6:0] e [7];
    s = '{mk(1,0,0,0,0,0,0), mk(0,0,0,1,0,0,0), mk(0,0,0,0,3,3,0), mk(0,0,0,1,7,7,1),
          mk(0,0,0,1,7,6,8), mk(0,0,0,1,7,6,8), mk(0,0,0,1,31,2,31)};
    e = '{RST, DEF, DEF, LU, DEF, DEF, LU};
    for (int i = 0; i < 7; i++) begin
      apply(s[i]);
      checks++;
      if (outs !== e[i]) begin
        errors++;
        $display("FAIL rd_zero[%0d] got=%b expected=%b", i, outs, e[i]);
      end
    end
  endtask

  task automatic test_back_to_back_reset();
    stim_t s [6];
    logic [6:0] e [6];
    s = '{mk(1,0,0,0,0,0,0), mk(0,0,1,0,0,0,0), mk(0,1,0,0,0,0,0), mk(1,1,0,0,0,0,0),
          mk(0,0,0,0,0,0,0), mk(0,0,0,0,0,0,0)};
    e = '{RST, BR, MEMW, RST, DEF, DEF};
    for (int i = 0; i < 6; i++) begin
      apply(s[i]);
      checks++;
      if (outs !== e[i]) begin
        errors++;
        $display("FAIL reset_mid[%0d] got=%b expected=%b", i, outs, e[i]);
      end
    end
`ifdef HAZARD_PERF_EN
    checks++;
    if (stall_cycles !== 16'd0 || flush_events !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_counters got=%0d/%0d expected=0/0", stall_cycles, flush_events);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_branch_and_load_use();
    test_rd_zero();
    test_back_to_back_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Clocking SHALL be one clock, clk; reset is synchronous and active-high.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the performance counters.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 branch_taken  in  1  EX-stage branch resolution (the Branch_Control switch_branch output).
REQ-006 ex_mem_read  in  1  EX-stage instruction is a load.
REQ-007 ex_rd, id_rs1, id_rs2  in  5 each  EX destination register and ID source registers.
REQ-008 mem_busy  in  1  data memory not ready; the pipeline must freeze.
REQ-009 pc_write, ifid_write, idex_write, exmem_write  out  1 each  pipeline register load enables.
REQ-010 ifid_flush, idex_flush, memwb_flush  out  1 each  bubble-insert controls.
REQ-011 stall_cycles, flush_events  out  CNT_W each  performance counters (present only under REQ-030).

Function
REQ-012 The block SHALL have FSM states RUN, LU_STALL, REDIRECT and MEM_WAIT, plus a 2-bit resume register holding RUN, LU_STALL or REDIRECT.
REQ-013 Outputs SHALL be combinational functions of the effective state, the inputs and reset; the effective state is resume when state=MEM_WAIT and mem_busy=0, otherwise it is state.
REQ-014 load_use SHALL be ex_mem_read && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2).
REQ-015 Evaluation priority in every effective state SHALL be mem_busy > branch_taken > load_use.
REQ-016 Default outputs: all *_write=1 and all *_flush=0.
REQ-017 For mem_busy=1 in any state, all *_write SHALL be 0, memwb_flush SHALL be 1, and other flushes 0.
  - On entry from a non-MEM_WAIT state, resume SHALL be loaded with that state.
  - Next state SHALL be MEM_WAIT.
REQ-018 In MEM_WAIT with mem_busy=0, the block SHALL produce the resume state's outputs and transitions in that same cycle (zero-cycle exit).
REQ-019 RUN with branch_taken=1: pc_write=1, ifid_flush=1, idex_flush=1; next state REDIRECT.
REQ-020 RUN with load_use=1 and branch_taken=0: pc_write=0, ifid_write=0, idex_flush=1; next state LU_STALL.
REQ-021 LU_STALL: default outputs, with load_use and branch_taken ignored; next state RUN.
REQ-022 REDIRECT: pc_write=1, ifid_flush=1, other defaults, with load_use and branch_taken ignored; next state RUN (target-fetch bubble).
REQ-023 A simultaneous branch_taken and load_use SHALL be treated as a branch only; no stall is inserted.

Reset
REQ-024 While reset=1, the block SHALL force all *_write=0, ifid_flush=idex_flush=memwb_flush=1, state<=RUN and resume<=RUN.
REQ-025 Reset asserted mid-MEM_WAIT or mid-REDIRECT SHALL discard the pending state; the first cycle after reset is RUN.
REQ-026 Counters SHALL clear to 0 on reset.

Configuration
REQ-027 Macro HAZARD_PERF_EN SHALL gate the performance counters.
REQ-028 With HAZARD_PERF_EN defined, stall_cycles SHALL increment on each non-reset cycle with pc_write=0, saturating at all-ones.
REQ-029 With HAZARD_PERF_EN defined, flush_events SHALL increment on each transition into REDIRECT, saturating at all-ones.
REQ-030 Without HAZARD_PERF_EN, the counter ports and registers SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 Package hazard_pkg SHALL hold the state enum, the resume encoding and the constant REG_W=5.
REQ-032 The load_use comparator SHALL be a sub-module, hazard_detect, with purely combinational ports ex_mem_read, ex_rd, id_rs1, id_rs2 -> load_use.

Verification
REQ-033 ex_mem_read=1, ex_rd=5, id_rs2=5 in RUN -> one cycle of pc_write=0, ifid_write=0, idex_flush=1, then LU_STALL with defaults, then RUN.
REQ-034 branch_taken=1 in RUN -> cycle 0: ifid_flush=idex_flush=1; cycle 1: ifid_flush=1 only; cycle 2: defaults; flush_events=1.
REQ-035 mem_busy=1 for 3 cycles, starting in REDIRECT -> 3 cycles of writes=0 and memwb_flush=1; the 4th cycle gives REDIRECT outputs; stall_cycles=3.
REQ-036 branch_taken=1 and load_use=1 in the same cycle -> branch outputs only, no LU_STALL.
REQ-037 ex_rd=0 with a matching rs1=0 and ex_mem_read=1 -> no stall.
REQ-038 reset=1 during MEM_WAIT -> forced reset outputs; next cycle RUN defaults with counters at 0.
